// File: rtl/hs32_execute.sv
// HS32 execute stage: operand select, ALU, NZCV flags and a one-entry
// result register that feeds forwarding and the regfile write port.
package hs32_pkg;

   typedef struct packed {
      logic       neg;
      logic       sub;
      logic       cen;
      logic [1:0] opr;
      logic       fwe;
   } hs32_ctl_t;

   typedef struct packed {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        we1;
      logic        we2;
      logic [3:0]  rd;
      logic        fwd;
      hs32_ctl_t   ctl;
   } hs32_s2pkt;

   typedef struct packed {
      logic [31:0] res;
   } hs32_s3pkt;

endpackage

module hs32_execute
   import hs32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  hs32_s2pkt   data_i,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic        flush_i,
   input  logic        ready_i,
   output hs32_s3pkt   fwd_o,
   output logic [3:0]  rd3_o,
   output logic        stl3_o,
   output logic [3:0]  wp_addr_o,
   output logic [31:0] wp_data_o,
   output logic        wp_we_o,
   output logic [3:0]  flags_o
);

   logic        valid_q;
   logic        we1_q;
   logic [31:0] res_q;
   logic [3:0]  rd_q;
   logic        n_q;
   logic        z_q;
   logic        c_q;
   logic        v_q;

   logic [31:0] opa;
   logic [31:0] opb;
   logic        cin;
   logic [32:0] sum;
   logic [31:0] res;
   logic        ovf;
   logic        accept;
   logic        unused_we2;

   // we2 is reserved: there is only one write port
   assign unused_we2 = data_i.we2;

   assign ready_o = ~valid_q | ready_i;
   assign accept  = valid_i & ready_o & ~flush_i;

   // operand select and ALU; carry-in uses the registered C flag
   always_comb begin
      opa = data_i.fwd ? res_q : data_i.d1;
      opb = data_i.ctl.neg ? ~data_i.d2 : data_i.d2;
      cin = data_i.ctl.cen ? c_q : data_i.ctl.sub;
      sum = {1'b0, opa} + {1'b0, opb} + {32'd0, cin};
      ovf = (opa[31] == opb[31]) & (sum[31] != opa[31]);
      case (data_i.ctl.opr)
         2'd0:    res = sum[31:0];
         2'd1:    res = opa & opb;
         2'd2:    res = opa | opb;
         default: res = opa ^ opb;
      endcase
   end

   // stage register: flush kills, accept loads, retire empties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         we1_q   <= 1'b0;
         res_q   <= 32'd0;
         rd_q    <= 4'd0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         we1_q   <= data_i.we1;
         res_q   <= res;
         rd_q    <= data_i.rd;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   // flags: N/Z on every flag-writing accept, C/V only for add
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q <= 1'b0;
         z_q <= 1'b0;
         c_q <= 1'b0;
         v_q <= 1'b0;
      end else if (accept && data_i.ctl.fwe) begin
         n_q <= res[31];
         z_q <= (res == 32'd0);
         if (data_i.ctl.opr == 2'd0) begin
            c_q <= sum[32];
            v_q <= ovf;
         end
      end
   end

   assign fwd_o.res = res_q;
   assign rd3_o     = rd_q;
   assign stl3_o    = valid_q & we1_q;
   assign wp_addr_o = rd_q;
   assign wp_data_o = res_q;
   assign wp_we_o   = valid_q & we1_q & ready_i & ~flush_i;
   assign flags_o   = {n_q, z_q, c_q, v_q};

endmodule
